instr_issue_unit: RTL

- Instruction-side front end of the MIPS datapath: PC register, program-loadable instruction memory, and branch/jump next-PC logic.
- Fetches one word at a time and presents it to the CPU core as instrword with a one-cycle newinstr strobe.
- Holds each word stable for a fixed issue window so the core's control FSM can complete; samples the core's ALU zero flag to resolve beq/bne.

---
 rtl/instr_issue_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_issue_unit.sv
// Instruction issue front end: PC, program-loadable instruction memory, beq/bne/j next-PC logic.
// Optional issued-instruction counter is enabled by defining ISSUE_COUNT_EN.
module instr_issue_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          ISSUE_GAP  = 4,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          alu_zero,
  output logic [31:0]   instrword,
  output logic          newinstr,
  output logic [31:0]   pc,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   issue_count
);

  localparam int          CW       = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(ISSUE_GAP - 1);
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t          r_state;
  logic [31:0]     r_mem [IMEM_DEPTH];
  logic [31:0]     r_rdata;
  logic [31:0]     r_instr;
  logic [31:0]     r_pc;
  logic [CW-1:0]   r_wait;
  logic            r_newinstr;
  logic            r_busy;
  logic            r_halted;
  logic            r_fault;

  logic            w_ctrl_idle;
  logic            w_prog_ok;
  logic            w_is_halt;
  logic [5:0]      w_opcode;
  logic [31:0]     w_pc4;
  logic [31:0]     w_br_tgt;
  logic [31:0]     w_jmp_tgt;
  logic [31:0]     w_next_pc;

  assign w_ctrl_idle = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_prog_ok   = prog_we && w_ctrl_idle;
  assign w_is_halt   = (r_rdata == HALT_WORD);

  always_ff @(posedge clock) begin
    if (w_prog_ok)
      r_mem[prog_addr] <= prog_data;
    if (r_state == S_FETCH)
      r_rdata <= r_mem[r_pc[AW+1:2]];
  end

  // Next PC is derived from the word already held on instrword; alu_zero only matters at the WAIT exit.
  assign w_opcode  = r_instr[31:26];
  assign w_pc4     = r_pc + 32'd4;
  assign w_br_tgt  = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jmp_tgt = {w_pc4[31:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    case (w_opcode)
      6'd4:    if (alu_zero)  w_next_pc = w_br_tgt;
      6'd5:    if (!alu_zero) w_next_pc = w_br_tgt;
      6'd2:    w_next_pc = w_jmp_tgt;
      default: w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_wait     <= '0;
      r_newinstr <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_newinstr <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
          end
        end
        S_FETCH: r_state <= S_ISSUE;
        S_ISSUE: begin
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_instr    <= r_rdata;
            r_newinstr <= 1'b1;
            r_wait     <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_wait <= '0;
            if (w_next_pc >= PC_LIMIT) begin
              r_state  <= S_HALT;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_fault  <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_FETCH;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instrword = r_instr;
  assign newinstr  = r_newinstr;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign fault     = r_fault;

`ifdef ISSUE_COUNT_EN
  logic        w_start_ok;
  logic        w_issue;
  logic [31:0] r_issue_count;

  assign w_start_ok = start && w_ctrl_idle;
  assign w_issue    = (r_state == S_ISSUE) && !w_is_halt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_issue_count <= '0;
    else if (w_start_ok)
      r_issue_count <= '0;
    else if (w_issue)
      r_issue_count <= r_issue_count + 32'd1;
  end

  assign issue_count = r_issue_count;
`else
  assign issue_count = '0;
`endif

endmodule
